elastic_bus_feedthrough: RTL and testbench

//  Registered, back-pressure-aware successor to the combinational two-operand bus cell.

---
 rtl/ft_pkg.sv | 20 ++
 rtl/ft_skid_stage.sv | 55 +++++
 rtl/elastic_bus_feedthrough.sv | 102 ++++++++++
 tb/tb_elastic_bus_feedthrough.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ft_pkg.sv
// Shared operator codes, stage limit and the per-bit combine function.
package ft_pkg;

  localparam int OP_PASS    = 0;
  localparam int OP_XOR     = 1;
  localparam int OP_AND     = 2;
  localparam int OP_OR      = 3;
  localparam int MAX_STAGES = 8;

  // Bitwise combine: applied bit by bit, so channels never interact.
  function automatic logic ft_combine(input int op, input logic a, input logic b);
    case (op)
      OP_XOR:  return a ^ b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      default: return a;
    endcase
  endfunction

endpackage

// File: rtl/ft_skid_stage.sv
// One elastic stage: main register plus skid register. Ready is a flop
// (!skid_valid), so ready never ripples combinationally along the chain.
module ft_skid_stage
  import ft_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          m_v, s_v;
  logic [DW-1:0] m_d, s_d;
  logic          in_xfer, drain;

  assign in_ready  = !s_v;
  assign out_valid = m_v;
  assign out_data  = m_d;
  assign in_xfer   = in_valid && !s_v;
  assign drain     = m_v && out_ready;

  // Main/skid update: refill main from skid first, park in skid only when main stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_v <= 1'b0;
      s_v <= 1'b0;
      m_d <= '0;
      s_d <= '0;
    end else if (drain) begin
      if (s_v) begin
        m_d <= s_d;
        s_v <= 1'b0;
      end else if (in_xfer) begin
        m_d <= in_data;
      end else begin
        m_v <= 1'b0;
      end
    end else if (!m_v) begin
      if (in_xfer) begin
        m_v <= 1'b1;
        m_d <= in_data;
      end
    end else if (in_xfer) begin
      s_v <= 1'b1;
      s_d <= in_data;
    end
  end

endmodule

// File: rtl/elastic_bus_feedthrough.sv
// Combines two multi-channel buses and retimes the result through a chain of
// skid stages; tracks occupancy and flags long input stalls.
module elastic_bus_feedthrough
  import ft_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 2,
  parameter int STAGES   = 2,
  parameter int OP       = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [CHANNELS*WIDTH-1:0]        in0,
  input  logic [CHANNELS*WIDTH-1:0]        in1,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [CHANNELS*WIDTH-1:0]        out,
  output logic [$clog2(2*STAGES+1)-1:0]    occupancy,
  output logic                             overflow
);

  localparam int DW  = CHANNELS * WIDTH;
  localparam int OW  = $clog2(2*STAGES+1);
  localparam int CAP = 2 * STAGES;

  if (OP < OP_PASS || OP > OP_OR) begin : g_bad_op
    $error("elastic_bus_feedthrough: OP must be 0..3");
  end
  if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
    $error("elastic_bus_feedthrough: STAGES must be 1..8");
  end

  logic [DW-1:0]               comb;
  logic [STAGES:0]             v, r;
  logic [STAGES:0][DW-1:0]     d;
  logic                        in_xfer, out_xfer;
  logic [7:0]                  stall_cnt, stall_nxt;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      assign comb[c*WIDTH+b] = ft_combine(OP, in0[c*WIDTH+b], in1[c*WIDTH+b]);
    end
  end

  assign v[0]      = in_valid;
  assign d[0]      = comb;
  assign r[STAGES] = out_ready;
  assign in_ready  = r[0] && !reset;
  assign out_valid = v[STAGES];
  assign out       = d[STAGES];
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    ft_skid_stage #(.DW(DW)) u_stage (
      .clk      (clk),
      .reset    (reset),
      .in_valid (v[s]),
      .in_ready (r[s]),
      .in_data  (d[s]),
      .out_valid(v[s+1]),
      .out_ready(r[s+1]),
      .out_data (d[s+1])
    );
  end

  // Occupancy: net of accepted and delivered words this cycle.
  always_ff @(posedge clk) begin
    if (reset) occupancy <= '0;
    else if (in_xfer && !out_xfer) occupancy <= occupancy + OW'(1);
    else if (out_xfer && !in_xfer) occupancy <= occupancy - OW'(1);
  end

  // Stall counter next value: cleared by any accept, saturates at 255.
  always_comb begin
    stall_nxt = stall_cnt;
    if (in_xfer) stall_nxt = '0;
    else if (in_valid && !in_ready && stall_cnt != 8'hff) stall_nxt = stall_cnt + 8'd1;
  end

  // Stall counter and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      stall_cnt <= stall_nxt;
      if (stall_nxt == 8'hff) overflow <= 1'b1;
    end
  end

  // Occupancy must never exceed capacity nor go negative.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(occupancy == OW'(CAP) && in_xfer && !out_xfer));
      assert (!(occupancy == '0 && out_xfer && !in_xfer));
    end
  end

endmodule

// File: tb/tb_elastic_bus_feedthrough.sv
// Directed bench: reset, fill latency, streaming, stall/capacity, random
// traffic against a queue, mid-flight reset and stall overflow.
module tb_elastic_bus_feedthrough;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [3:0] in0 = '0, in1 = '0;
  logic       in_ready, out_valid, overflow;
  logic [3:0] out;
  logic [2:0] occupancy;
  logic       in_ready_o, out_valid_o, overflow_o;
  logic [3:0] out_o;
  logic [2:0] occupancy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  elastic_bus_feedthrough #(.WIDTH(2), .CHANNELS(2), .STAGES(2), .OP(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in0(in0), .in1(in1), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .occupancy(occupancy), .overflow(overflow)
  );

  elastic_bus_feedthrough #(.WIDTH(2), .CHANNELS(2), .STAGES(2), .OP(3)) dut_or (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_o),
    .in0(in0), .in1(in1), .out_valid(out_valid_o), .out_ready(out_ready),
    .out(out_o), .occupancy(occupancy_o), .overflow(overflow_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] q[$];
    logic [3:0] e;
    int nin, nout, first, acc, rdy_cyc, fall, rise;

    // Reset cycle
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_in_ready_or", in_ready_o, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_ovf", overflow, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Fill: 1010 ^ 0110 = 1100, 1010 | 0110 = 1110, two-cycle latency
    in_valid = 1'b1; in0 = 4'b1010; in1 = 4'b0110;
    tick();
    in_valid = 1'b0;
    chk("fill_occ1", occupancy, 1);
    chk("fill_vld_early", out_valid, 0);
    tick();
    chk("fill_vld", out_valid, 1);
    chk("fill_xor", out, 4'b1100);
    chk("fill_or_vld", out_valid_o, 1);
    chk("fill_or", out_o, 4'b1110);
    chk("fill_or_occ", occupancy_o, 1);
    chk("fill_occ_hold", occupancy, 1);
    tick();
    chk("fill_occ0", occupancy, 0);
    chk("fill_drained", out_valid, 0);

    // Stream 0..15 back-to-back (in1=0 so XOR passes in0)
    in1 = '0; nin = 0; nout = 0; first = -1;
    for (int cyc = 0; cyc < 40 && nout < 16; cyc++) begin
      in_valid = (nin < 16);
      in0 = nin[3:0];
      #1;
      acc = int'(in_valid && in_ready);
      if (out_valid) begin
        if (first < 0) first = cyc;
        chk("stream_data", out, nout);
        nout++;
      end else if (nout > 0) begin
        chk("stream_bubble", out_valid, 1);
      end
      tick();
      nin += acc;
    end
    in_valid = 1'b0;
    chk("stream_count", nout, 16);
    chk("stream_latency", first, 2);

    // Stall: capacity 4, then ordered drain
    out_ready = 1'b0; in_valid = 1'b1; acc = 0;
    for (int i = 0; i < 10; i++) begin
      in0 = 4'(8 + acc);
      #1;
      if (in_ready) acc++;
      tick();
    end
    chk("stall_accepted", acc, 4);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_occ", occupancy, 4);
    in_valid = 1'b0; out_ready = 1'b1; nout = 0; rdy_cyc = -1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (out_valid) begin
        chk("stall_order", out, 8 + nout);
        nout++;
      end
      if (in_ready && rdy_cyc < 0) rdy_cyc = i;
      tick();
    end
    chk("stall_drain_count", nout, 4);
    chk("stall_ready_return", rdy_cyc, 2);

    // Random traffic against a FIFO scoreboard
    for (int i = 0; i < 2000; i++) begin
      in_valid = 1'($urandom % 2);
      out_ready = 1'($urandom % 2);
      in0 = 4'($urandom);
      #1;
      chk("rand_occ", occupancy, q.size());
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("rand_nonempty", out_valid, 0);
        else begin
          e = q.pop_front();
          chk("rand_data", out, e);
        end
      end
      if (in_valid && in_ready) q.push_back(in0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) tick();
    chk("rand_final_occ", occupancy, 0);

    // Reset mid-flight discards 3 words, then 0x5 passes
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      in0 = 4'(k);
      tick();
    end
    in_valid = 1'b0;
    chk("mid_occ_before", occupancy, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_vld", out_valid, 0);
    chk("mid_occ", occupancy, 0);
    in0 = 4'h5; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; nout = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) begin
        chk("mid_word", out, 5);
        nout++;
      end
      tick();
    end
    chk("mid_count", nout, 1);

    // Overflow after 255 stalled cycles, sticky until reset
    chk("ovf_pre", overflow, 0);
    out_ready = 1'b0; in_valid = 1'b1; in0 = '0; fall = -1; rise = -1;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (!in_ready && fall < 0) fall = i;
      if (overflow && rise < 0) rise = i;
      tick();
    end
    chk("ovf_seen", int'(rise >= 0 && fall >= 0), 1);
    chk("ovf_delay", rise - fall, 255);
    chk("ovf_or_inst", overflow_o, 1);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) tick();
    chk("ovf_sticky", overflow, 1);
    chk("ovf_drained_occ", occupancy, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("ovf_cleared", overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
